fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/shared_pkg.sv | 23 ++
 rtl/fifo_rd_stream.sv | 115 +++++++++++
 2 files changed

// File: rtl/shared_pkg.sv
// Shared constants for the FIFO read-stream path: data width, output
// buffer depth, statistics counter width and a pointer-wrap helper.
package shared_pkg;

    localparam int FIFO_WIDTH    = 16;
    localparam int BUF_DEPTH     = 3;
    localparam int CNT_W_DEFAULT = 16;

    // Last valid index of the 3-entry output buffer.
    localparam logic [1:0] PTR_LAST = 2'd2;

    // Advance a buffer pointer, wrapping from the last entry back to 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        logic [1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = 2'd0;
        end else begin
            nxt = ptr + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains a registered-output FIFO into a valid/ready stream through a
// 3-entry circular buffer. A read accepted at one edge lands in the
// buffer on the next edge; three entries cover that round trip so the
// stream runs at one word per cycle without the read request ever
// looking at m_ready. Also keeps a transfer counter and a sticky
// underflow flag.
module fifo_rd_stream
    import shared_pkg::*;
#(
    parameter int DATA_W    = FIFO_WIDTH,
    parameter int BUF_DEPTH = shared_pkg::BUF_DEPTH,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_underflow,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              clr_stat,
    output logic [CNT_W-1:0]  words_out,
    output logic              underflow_seen
);

    logic [DATA_W-1:0] buf_r [BUF_DEPTH];
    logic [1:0]        occ_r;
    logic [1:0]        rd_ptr_r;
    logic [1:0]        wr_ptr_r;
    logic              inflight_r;
    logic [CNT_W-1:0]  words_out_r;
    logic              underflow_seen_r;

    logic              rd_acc_s;
    logic              pop_s;
    logic              land_s;
    logic [2:0]        committed_s;

    // Entries already held plus the one still on its way from the FIFO.
    assign committed_s = {1'b0, occ_r} + {2'b00, inflight_r};

    // Read request: only when a free slot is guaranteed for the returning word.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && !fifo_empty && (committed_s < 3'(BUF_DEPTH))) begin
            fifo_rd_en = 1'b1;
        end else begin
            fifo_rd_en = 1'b0;
        end
    end

    assign rd_acc_s = fifo_rd_en && !fifo_empty;
    assign pop_s    = (occ_r != 2'd0) && m_ready;
    assign land_s   = inflight_r;

    // Buffer storage, pointers, occupancy and the in-flight read marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
            occ_r      <= 2'd0;
            rd_ptr_r   <= 2'd0;
            wr_ptr_r   <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_acc_s;
            if (land_s) begin
                buf_r[wr_ptr_r] <= fifo_data_out;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({land_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Transfer counter (clear beats increment) and sticky underflow (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_out_r      <= '0;
            underflow_seen_r <= 1'b0;
        end else begin
            if (clr_stat) begin
                words_out_r <= '0;
            end else if (pop_s) begin
                words_out_r <= words_out_r + CNT_W'(1);
            end
            if (fifo_underflow) begin
                underflow_seen_r <= 1'b1;
            end else if (clr_stat) begin
                underflow_seen_r <= 1'b0;
            end
        end
    end

    assign m_valid        = (occ_r != 2'd0);
    assign m_data         = buf_r[rd_ptr_r];
    assign words_out      = words_out_r;
    assign underflow_seen = underflow_seen_r;

`ifdef SIM
    // A word must never land into a full buffer.
    a_no_land_when_full: assert property (@(posedge clk) disable iff (rst)
        !(inflight_r && (occ_r == 2'd3)));
`endif

endmodule
